// File: rtl/tl_pkg.sv
// tl_pkg: light encodings and default sensor parameters shared with the controller
package tl_pkg;
  localparam logic [1:0] GREEN = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;
  localparam int QW_DEF = 4;
  localparam int DEPART_CYC_DEF = 2;
endpackage

// File: rtl/tl_lane.sv
// tl_lane: per-street vehicle queue with green-time departure timer and sticky saturation flag
module tl_lane
  import tl_pkg::*;
#(
  parameter int QW = QW_DEF,
  parameter int DEPART_CYC = DEPART_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          arr,
  input  logic [1:0]    light,
  output logic [QW-1:0] q,
  output logic          dep,
  output logic          sat
);
  logic [3:0] t;
  logic go, fire, full;
  always_comb begin
    go = light == GREEN && q != '0;
    fire = go && t == 4'(DEPART_CYC - 1);
    full = q == '1;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
      t <= '0;
      dep <= 1'b0;
      sat <= 1'b0;
    end else begin
      t <= (go && !fire) ? t + 4'd1 : 4'd0;
      dep <= fire;
      q <= (arr && !fire) ? (full ? q : q + 1'b1) : (!arr && fire) ? q - 1'b1 : q;
      sat <= sat | (arr && !fire && full);
    end
  end
endmodule

// File: rtl/tl_sensor.sv
// tl_sensor: two-street traffic sensor feeding presence flags to the light controller
module tl_sensor
  import tl_pkg::*;
#(
  parameter int QW = QW_DEF,
  parameter int DEPART_CYC = DEPART_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          arr_a,
  input  logic          arr_b,
  input  logic [1:0]    La,
  input  logic [1:0]    Lb,
  output logic          Ta,
  output logic          Tb,
  output logic [QW-1:0] qa,
  output logic [QW-1:0] qb,
  output logic          dep_a,
  output logic          dep_b,
  output logic          ovf,
  output logic          err
);
  logic sat_a, sat_b;
  tl_lane #(.QW(QW), .DEPART_CYC(DEPART_CYC)) u_lane_a (
    .clk(clk), .reset_n(reset_n), .arr(arr_a), .light(La), .q(qa), .dep(dep_a), .sat(sat_a)
  );
  tl_lane #(.QW(QW), .DEPART_CYC(DEPART_CYC)) u_lane_b (
    .clk(clk), .reset_n(reset_n), .arr(arr_b), .light(Lb), .q(qb), .dep(dep_b), .sat(sat_b)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) err <= 1'b0;
    else err <= err | (La == GREEN && Lb == GREEN) | La == ILLEGAL | Lb == ILLEGAL;
  end
  always_comb begin
    Ta = qa != '0;
    Tb = qb != '0;
    ovf = sat_a | sat_b;
  end
endmodule

// File: tb/tb_tl_sensor.sv
// tb_tl_sensor: directed scenarios plus randomized traffic against a behavioural queue model
module tb_tl_sensor;
  localparam int D = 2;
  localparam int QMAX = 15;
  logic clk = 1'b0;
  logic reset_n, arr_a, arr_b, Ta, Tb, dep_a, dep_b, ovf, err;
  logic [1:0] La, Lb;
  logic [3:0] qa, qb;
  int checks = 0;
  int errors = 0;
  int mqa, mqb, mra, mrb, mda, mdb;
  logic movf, merr;
  tl_sensor #(.QW(4), .DEPART_CYC(D)) dut (
    .clk(clk), .reset_n(reset_n), .arr_a(arr_a), .arr_b(arr_b), .La(La), .Lb(Lb),
    .Ta(Ta), .Tb(Tb), .qa(qa), .qb(qb), .dep_a(dep_a), .dep_b(dep_b), .ovf(ovf), .err(err)
  );
  always #5 clk = ~clk;
  task automatic lane(input int q_i, input int r_i, input logic arr, input logic [1:0] l,
                      output int q_o, output int r_o, output int d_o, output logic s);
    bit moving;
    moving = (l == 2'b00) && q_i > 0;
    d_o = (moving && r_i == D - 1) ? 1 : 0;
    r_o = (moving && d_o == 0) ? r_i + 1 : 0;
    s = arr && d_o == 0 && q_i == QMAX;
    q_o = s ? q_i : q_i + int'(arr) - d_o;
  endtask
  task automatic cycle(input logic r, input logic aa, input logic ab, input logic [1:0] la, input logic [1:0] lb);
    logic sa, sb;
    reset_n = r; arr_a = aa; arr_b = ab; La = la; Lb = lb;
    @(posedge clk);
    if (!r) begin
      mqa = 0; mqb = 0; mra = 0; mrb = 0; mda = 0; mdb = 0; movf = 0; merr = 0;
    end else begin
      lane(mqa, mra, aa, la, mqa, mra, mda, sa);
      lane(mqb, mrb, ab, lb, mqb, mrb, mdb, sb);
      movf = movf | sa | sb;
      merr = merr | (la == 2'b00 && lb == 2'b00) | (la == 2'b11) | (lb == 2'b11);
    end
    #1;
  endtask
  task automatic do_reset();
    cycle(0, 0, 0, 2'b10, 2'b10);
    cycle(0, 0, 0, 2'b10, 2'b10);
    cycle(1, 0, 0, 2'b10, 2'b10);
  endtask
  task automatic test_reset();
    cycle(0, 1, 1, 2'b00, 2'b10);
    cycle(0, 1, 1, 2'b00, 2'b10);
    checks++;
    if ({qa, qb, Ta, Tb, dep_a, dep_b, ovf, err} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got qa=%0d qb=%0d Ta=%b Tb=%b dep=%b%b ovf=%b err=%b want all 0", qa, qb, Ta, Tb, dep_a, dep_b, ovf, err);
    end
    cycle(1, 0, 0, 2'b10, 2'b10);
    checks++;
    if (qa !== 4'd0) begin errors++; $display("FAIL reset_release_qa got %0d want 0", qa); end
  endtask
  task automatic test_drain();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 2'b10, 2'b10);
    checks++;
    if (qa !== 4'd3 || Ta !== 1'b1) begin errors++; $display("FAIL drain_fill got qa=%0d Ta=%b want 3 1", qa, Ta); end
    for (int i = 1; i <= 6; i++) begin
      cycle(1, 0, 0, 2'b00, 2'b10);
      checks++;
      if (dep_a !== (i % 2 == 0) || qa !== 4'(3 - i / 2)) begin
        errors++;
        $display("FAIL drain_cycle%0d got dep_a=%b qa=%0d want %b %0d", i, dep_a, qa, i % 2 == 0, 3 - i / 2);
      end
    end
    checks++;
    if (Ta !== 1'b0) begin errors++; $display("FAIL drain_empty_Ta got %b want 0", Ta); end
  endtask
  task automatic test_simultaneous();
    do_reset();
    cycle(1, 1, 0, 2'b10, 2'b10);
    cycle(1, 0, 0, 2'b00, 2'b10);
    cycle(1, 1, 0, 2'b00, 2'b10);
    checks++;
    if (dep_a !== 1'b1 || qa !== 4'd1 || Ta !== 1'b1) begin
      errors++;
      $display("FAIL simultaneous got dep_a=%b qa=%0d Ta=%b want 1 1 1", dep_a, qa, Ta);
    end
  endtask
  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 19; i++) begin
      cycle(1, 0, 1, 2'b10, 2'b10);
      if (i >= 15) begin
        checks++;
        if (qb !== 4'd15 || ovf !== (i >= 16)) begin
          errors++;
          $display("FAIL saturation_arr%0d got qb=%0d ovf=%b want 15 %b", i, qb, ovf, i >= 16);
        end
      end
    end
  endtask
  task automatic test_yellow();
    do_reset();
    cycle(1, 1, 0, 2'b10, 2'b10);
    cycle(1, 1, 0, 2'b10, 2'b10);
    cycle(1, 0, 0, 2'b00, 2'b10);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 2'b01, 2'b10);
      checks++;
      if (dep_a !== 1'b0 || qa !== 4'd2) begin errors++; $display("FAIL yellow_hold%0d got dep_a=%b qa=%0d want 0 2", i, dep_a, qa); end
    end
    cycle(1, 0, 0, 2'b00, 2'b10);
    checks++;
    if (dep_a !== 1'b0) begin errors++; $display("FAIL yellow_timer_cleared got dep_a=%b want 0", dep_a); end
    cycle(1, 0, 0, 2'b00, 2'b10);
    checks++;
    if (dep_a !== 1'b1 || qa !== 4'd1) begin errors++; $display("FAIL yellow_resume got dep_a=%b qa=%0d want 1 1", dep_a, qa); end
  endtask
  task automatic test_illegal();
    do_reset();
    cycle(1, 0, 0, 2'b00, 2'b00);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL illegal_both_green got err=%b want 1", err); end
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 2'b10, 2'b00);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL illegal_sticky got err=%b want 1", err); end
    do_reset();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL illegal_reset_clear got err=%b want 0", err); end
    cycle(1, 0, 0, 2'b10, 2'b11);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL illegal_code11 got err=%b want 1", err); end
  endtask
  task automatic test_random();
    logic [1:0] la, lb;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      la = 2'($urandom_range(0, 2));
      lb = la == 2'b00 ? 2'($urandom_range(1, 2)) : 2'($urandom_range(0, 2));
      cycle($urandom_range(0, 60) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, la, lb);
      checks++;
      if (qa !== 4'(mqa) || qb !== 4'(mqb) || Ta !== (mqa != 0) || Tb !== (mqb != 0) ||
          dep_a !== (mda != 0) || dep_b !== (mdb != 0) || ovf !== movf || err !== merr) begin
        errors++;
        $display("FAIL random_cycle%0d got qa=%0d qb=%0d dep=%b%b ovf=%b err=%b want qa=%0d qb=%0d dep=%0d%0d ovf=%b err=%b",
                 i, qa, qb, dep_a, dep_b, ovf, err, mqa, mqb, mda, mdb, movf, merr);
      end
    end
  endtask
  initial begin
    mqa = 0; mqb = 0; mra = 0; mrb = 0; mda = 0; mdb = 0; movf = 0; merr = 0;
    test_reset();
    test_drain();
    test_simultaneous();
    test_saturation();
    test_yellow();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
